// File: rtl/config_pkg.sv
// Shared types and elaboration helpers for the configuration loader.
package config_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Smallest n with 2**n >= value; used to size word addresses.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/config_bank.sv
// NUM_WORDS x WORD_W register bank with one word-write port, a whole-bank
// load port and a flat parallel view of all words.
module config_bank #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 35,
   parameter int ADDR_W    = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en_i,
   input  logic [ADDR_W-1:0]           wr_addr_i,
   input  logic [WORD_W-1:0]           wr_data_i,
   input  logic                        ld_en_i,
   input  logic [WORD_W*NUM_WORDS-1:0] ld_data_i,
   output logic [WORD_W*NUM_WORDS-1:0] data_o
);

   logic [WORD_W-1:0] mem_q [NUM_WORDS];

   // Word storage; a bulk load takes priority over a single-word write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (ld_en_i) begin
               mem_q[k] <= ld_data_i[k*WORD_W +: WORD_W];
            end else if (wr_en_i && (wr_addr_i == ADDR_W'(k))) begin
               mem_q[k] <= wr_data_i;
            end else begin
               mem_q[k] <= mem_q[k];
            end
         end
      end
   end

   // Flatten the register array; pure wiring, no logic in the path.
   always_comb begin
      data_o = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         data_o[k*WORD_W +: WORD_W] = mem_q[k];
      end
   end

endmodule

// File: rtl/config_loader.sv
// Double-buffered configuration loader: loads fill a shadow bank (sequential
// or addressed) and a commit copies it into the active bank that drives outputs.
module config_loader
   import config_pkg::*;
#(
   parameter  int WORD_W    = 32,
   parameter  int NUM_WORDS = 35,
   localparam int ADDR_W    = clog2(NUM_WORDS),
   localparam int CFG_W     = WORD_W * NUM_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_abort,
   input  logic              io_mode,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [WORD_W-1:0] io_d_in,
   input  logic              io_commit,
   input  logic [ADDR_W-1:0] io_rd_addr,
   output logic [WORD_W-1:0] io_rd_data,
   output logic [CFG_W-1:0]  io_configs_out,
   output logic              io_done,
   output logic              io_err
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              committed_q, committed_d;
   logic [WORD_W-1:0] rd_data_q, rd_data_d;

   logic              ready_s, idle_like_s, accept_s, addr_wr_s, addr_ok_s;
   logic              commit_bad_s, commit_s;
   logic              sh_wr_en_s;
   logic [ADDR_W-1:0] sh_wr_addr_s;
   logic [CFG_W-1:0]  shadow_s, active_s, commit_data_s;

   // Handshake, shadow write port and commit qualification.
   always_comb begin
      ready_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: ready_s = io_mode;
         ST_LOAD:          ready_s = 1'b1;
         ST_COMMIT:        ready_s = 1'b0;
         default:          ready_s = 1'b0;
      endcase
      idle_like_s  = (state_q == ST_IDLE) || (state_q == ST_DONE);
      accept_s     = io_in_valid & ready_s;
      addr_wr_s    = accept_s & idle_like_s;
      addr_ok_s    = (io_addr <= LAST_IDX);
      sh_wr_en_s   = (accept_s & (state_q == ST_LOAD)) | (addr_wr_s & addr_ok_s);
      sh_wr_addr_s = (state_q == ST_LOAD) ? cnt_q : io_addr;
      commit_bad_s = io_commit & ~idle_like_s;
      commit_s     = (io_commit & idle_like_s) | (state_q == ST_COMMIT);
   end

   // Commit image includes a word written in the same cycle; readback sees
   // the active contents as they will be after this edge.
   always_comb begin
      commit_data_s = shadow_s;
      rd_data_d     = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         commit_data_s[k*WORD_W +: WORD_W] =
            (sh_wr_en_s && (sh_wr_addr_s == ADDR_W'(k))) ? io_d_in
                                                         : shadow_s[k*WORD_W +: WORD_W];
         rd_data_d = rd_data_d | ({WORD_W{io_rd_addr == ADDR_W'(k)}} &
                     (commit_s ? commit_data_s[k*WORD_W +: WORD_W]
                               : active_s[k*WORD_W +: WORD_W]));
      end
   end

   // Next state, word counter and status flags.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      committed_d = committed_q | commit_s;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (io_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (io_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (io_start) begin
               cnt_d = '0;
            end else if (accept_s) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_COMMIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_COMMIT: state_d = ST_DONE;
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // An aborted reload falls back to whatever the untouched active bank holds.
      if ((state_q == ST_LOAD) && io_abort) begin
         done_d = committed_q;
      end else if (io_start && (state_q != ST_COMMIT)) begin
         done_d = 1'b0;
      end else if (commit_s) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end

      if (commit_bad_s || (addr_wr_s && !addr_ok_s)) begin
         err_d = 1'b1;
      end else if (io_start) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         committed_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         committed_q <= committed_d;
         rd_data_q   <= rd_data_d;
      end
   end

   config_bank #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (sh_wr_en_s),
      .wr_addr_i (sh_wr_addr_s),
      .wr_data_i (io_d_in),
      .ld_en_i   (1'b0),
      .ld_data_i ('0),
      .data_o    (shadow_s)
   );

   config_bank #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_active (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (1'b0),
      .wr_addr_i ('0),
      .wr_data_i ('0),
      .ld_en_i   (commit_s),
      .ld_data_i (commit_data_s),
      .data_o    (active_s)
   );

   assign io_in_ready    = ready_s & reset;
   assign io_rd_data     = rd_data_q;
   assign io_done        = done_q;
   assign io_err         = err_q;
   assign io_configs_out = active_s;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader against a word-array reference model.
module tb_config_loader;

   localparam int WW = 32;
   localparam int NW = 35;
   localparam int AW = 6;
   localparam int CW = WW * NW;

   logic          clk = 1'b0;
   logic          reset;
   logic          io_start, io_abort, io_mode, io_in_valid, io_commit;
   logic [AW-1:0] io_addr, io_rd_addr;
   logic [WW-1:0] io_d_in;
   logic          io_in_ready, io_done, io_err;
   logic [WW-1:0] io_rd_data;
   logic [CW-1:0] io_configs_out;

   config_loader dut (
      .clk            (clk),
      .reset          (reset),
      .io_start       (io_start),
      .io_abort       (io_abort),
      .io_mode        (io_mode),
      .io_addr        (io_addr),
      .io_in_valid    (io_in_valid),
      .io_in_ready    (io_in_ready),
      .io_d_in        (io_d_in),
      .io_commit      (io_commit),
      .io_rd_addr     (io_rd_addr),
      .io_rd_data     (io_rd_data),
      .io_configs_out (io_configs_out),
      .io_done        (io_done),
      .io_err         (io_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [WW-1:0] m_active [NW];
   logic [WW-1:0] m_shadow [NW];
   logic [WW-1:0] words    [NW];
   logic          m_done;
   logic          m_err;

   function automatic logic [CW-1:0] model_flat();
      logic [CW-1:0] r;
      r = '0;
      for (int k = 0; k < NW; k++) r[k*WW +: WW] = m_active[k];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      io_start = 1'b0; io_abort = 1'b0; io_mode = 1'b0; io_in_valid = 1'b0;
      io_commit = 1'b0; io_addr = '0; io_rd_addr = '0; io_d_in = '0;
   endtask

   task automatic model_clear();
      for (int k = 0; k < NW; k++) begin
         m_active[k] = '0;
         m_shadow[k] = '0;
      end
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   // Full sequential load of words[]; gap_mode 0 none, 1 every other cycle, 2 random.
   task automatic run_load(input int gap_mode, input string tag);
      io_mode = 1'b0; io_start = 1'b1;
      tick();
      io_start = 1'b0;
      m_err = 1'b0;
      n_checks++;
      if (io_done !== 1'b0) begin
         n_errors++; $display("FAIL %s_done_cleared_on_start: got %b expected 0", tag, io_done);
      end
      for (int k = 0; k < NW; k++) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            io_in_valid = 1'b0;
            tick();
            if (k == 3) begin
               n_checks++;
               if (io_in_ready !== 1'b1) begin
                  n_errors++; $display("FAIL %s_ready_in_gap: got %b expected 1", tag, io_in_ready);
               end
            end
         end
         io_in_valid = 1'b1; io_d_in = words[k];
         tick();
         m_shadow[k] = words[k];
      end
      io_in_valid = 1'b0;
      n_checks++;
      if (io_in_ready !== 1'b0) begin
         n_errors++; $display("FAIL %s_ready_in_commit: got %b expected 0", tag, io_in_ready);
      end
      n_checks++;
      if (io_configs_out !== model_flat()) begin
         n_errors++; $display("FAIL %s_active_before_commit: got %h expected %h", tag, io_configs_out, model_flat());
      end
      tick();
      m_active = words;
      m_done = 1'b1;
      n_checks++;
      if (io_done !== 1'b1) begin
         n_errors++; $display("FAIL %s_done: got %b expected 1", tag, io_done);
      end
      n_checks++;
      if (io_configs_out !== model_flat()) begin
         n_errors++; $display("FAIL %s_configs: got %h expected %h", tag, io_configs_out, model_flat());
      end
      n_checks++;
      if (io_err !== 1'b0) begin
         n_errors++; $display("FAIL %s_err: got %b expected 0", tag, io_err);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0; io_mode = 1'b1;
      model_clear();
      #12;
      n_checks++;
      if (io_configs_out !== '0) begin n_errors++; $display("FAIL reset_configs: got %h expected 0", io_configs_out); end
      n_checks++;
      if (io_rd_data !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h expected 0", io_rd_data); end
      n_checks++;
      if ({io_done, io_err} !== 2'b00) begin n_errors++; $display("FAIL reset_done_err: got %b expected 00", {io_done, io_err}); end
      n_checks++;
      if (io_in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_mode1: got %b expected 0", io_in_ready); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_checks++;
      if (io_in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready_mode1: got %b expected 1", io_in_ready); end
      io_mode = 1'b0;
      #1;
      n_checks++;
      if (io_in_ready !== 1'b0) begin n_errors++; $display("FAIL idle_ready_mode0: got %b expected 0", io_in_ready); end
   endtask

   task automatic test_seq_load();
      for (int k = 0; k < NW; k++) words[k] = 32'h1000_0000 + WW'(k);
      run_load(0, "seq");
      n_checks++;
      if (io_configs_out[31:0] !== 32'h1000_0000) begin
         n_errors++; $display("FAIL seq_word0: got %h expected 10000000", io_configs_out[31:0]);
      end
      n_checks++;
      if (io_configs_out[1119:1088] !== 32'h1000_0022) begin
         n_errors++; $display("FAIL seq_word34: got %h expected 10000022", io_configs_out[1119:1088]);
      end
   endtask

   task automatic test_readback();
      logic [WW-1:0] exp_w;
      int a;
      io_rd_addr = 6'd34;
      tick();
      n_checks++;
      if (io_rd_data !== 32'h1000_0022) begin n_errors++; $display("FAIL rd_34: got %h expected 10000022", io_rd_data); end
      io_rd_addr = 6'd63;
      tick();
      n_checks++;
      if (io_rd_data !== 32'h0) begin n_errors++; $display("FAIL rd_63: got %h expected 0", io_rd_data); end
      for (int i = 0; i < 8; i++) begin
         a = int'($urandom_range(0, 63));
         io_rd_addr = AW'(a);
         exp_w = (a < NW) ? m_active[a] : 32'h0;
         tick();
         n_checks++;
         if (io_rd_data !== exp_w) begin n_errors++; $display("FAIL rd_rand[%0d]: got %h expected %h", a, io_rd_data, exp_w); end
      end
   endtask

   task automatic test_abort();
      io_mode = 1'b0; io_start = 1'b1;
      tick();
      io_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         io_in_valid = 1'b1; io_d_in = 32'hDEAD_BEEF;
         tick();
      end
      io_in_valid = 1'b0;
      n_checks++;
      if (io_done !== 1'b0) begin n_errors++; $display("FAIL abort_done_during_load: got %b expected 0", io_done); end
      io_abort = 1'b1;
      tick();
      io_abort = 1'b0;
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL abort_configs: got %h expected %h", io_configs_out, model_flat()); end
      n_checks++;
      if (io_done !== 1'b1) begin n_errors++; $display("FAIL abort_done: got %b expected 1", io_done); end
      n_checks++;
      if (io_in_ready !== 1'b0) begin n_errors++; $display("FAIL abort_idle_ready: got %b expected 0", io_in_ready); end
      // start and abort together: abort wins
      io_start = 1'b1;
      tick();
      io_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         io_in_valid = 1'b1; io_d_in = $urandom;
         tick();
      end
      io_in_valid = 1'b0; io_start = 1'b1; io_abort = 1'b1;
      tick();
      io_start = 1'b0; io_abort = 1'b0;
      n_checks++;
      if (io_in_ready !== 1'b0) begin n_errors++; $display("FAIL abort_wins_ready: got %b expected 0", io_in_ready); end
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL abort_wins_configs: got %h expected %h", io_configs_out, model_flat()); end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < NW; k++) words[k] = 32'h1000_0000 + WW'(k);
      run_load(1, "gap_alt");
      for (int k = 0; k < NW; k++) words[k] = $urandom;
      run_load(2, "gap_rand");
   endtask

   task automatic test_addressed();
      int a;
      logic [WW-1:0] d;
      logic c, v;
      io_mode = 1'b1;
      #1;
      n_checks++;
      if (io_in_ready !== 1'b1) begin n_errors++; $display("FAIL addr_ready_done: got %b expected 1", io_in_ready); end
      io_in_valid = 1'b1; io_addr = 6'd7; io_d_in = 32'hA5A5_A5A5; io_commit = 1'b1; io_rd_addr = 6'd7;
      tick();
      io_in_valid = 1'b0; io_commit = 1'b0;
      m_shadow[7] = 32'hA5A5_A5A5;
      m_active = m_shadow;
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL addr7_commit: got %h expected %h", io_configs_out, model_flat()); end
      n_checks++;
      if (io_rd_data !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL addr7_readback: got %h expected a5a5a5a5", io_rd_data); end
      n_checks++;
      if (io_err !== 1'b0) begin n_errors++; $display("FAIL addr7_err: got %b expected 0", io_err); end
      io_in_valid = 1'b1; io_addr = 6'd40; io_d_in = $urandom;
      tick();
      io_in_valid = 1'b0; io_commit = 1'b1;
      tick();
      io_commit = 1'b0;
      m_err = 1'b1;
      n_checks++;
      if (io_err !== 1'b1) begin n_errors++; $display("FAIL addr40_err: got %b expected 1", io_err); end
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL addr40_nochange: got %h expected %h", io_configs_out, model_flat()); end
      for (int i = 0; i < 24; i++) begin
         a = int'($urandom_range(0, 63));
         d = $urandom;
         c = ($urandom_range(0, 3) == 0);
         v = ($urandom_range(0, 3) != 0);
         io_in_valid = v; io_addr = AW'(a); io_d_in = d; io_commit = c;
         tick();
         if (v) begin
            if (a < NW) m_shadow[a] = d;
            else m_err = 1'b1;
         end
         if (c) begin
            m_active = m_shadow;
            m_done = 1'b1;
         end
         n_checks++;
         if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL addr_rand[%0d]_configs: got %h expected %h", i, io_configs_out, model_flat()); end
         n_checks++;
         if ({io_err, io_done} !== {m_err, m_done}) begin n_errors++; $display("FAIL addr_rand[%0d]_flags: got %b expected %b", i, {io_err, io_done}, {m_err, m_done}); end
      end
      io_in_valid = 1'b0; io_commit = 1'b0; io_mode = 1'b0;
   endtask

   task automatic test_restart();
      io_mode = 1'b0; io_start = 1'b1;
      tick();
      io_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         io_in_valid = 1'b1; io_d_in = $urandom;
         tick();
      end
      io_commit = 1'b1; io_d_in = $urandom;
      tick();
      io_commit = 1'b0;
      n_checks++;
      if (io_err !== 1'b1) begin n_errors++; $display("FAIL commit_in_load_err: got %b expected 1", io_err); end
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL commit_in_load_ignored: got %h expected %h", io_configs_out, model_flat()); end
      io_start = 1'b1; io_d_in = $urandom;
      tick();
      io_start = 1'b0;
      n_checks++;
      if (io_err !== 1'b0) begin n_errors++; $display("FAIL restart_err_clear: got %b expected 0", io_err); end
      for (int k = 0; k < NW; k++) begin
         words[k] = $urandom;
         io_in_valid = 1'b1; io_d_in = words[k];
         tick();
         if (k == NW - 2) begin
            n_checks++;
            if (io_in_ready !== 1'b1) begin n_errors++; $display("FAIL restart_still_loading: got %b expected 1", io_in_ready); end
         end
      end
      io_in_valid = 1'b0;
      n_checks++;
      if (io_in_ready !== 1'b0) begin n_errors++; $display("FAIL restart_commit_ready: got %b expected 0", io_in_ready); end
      tick();
      m_active = words;
      m_done = 1'b1;
      n_checks++;
      if (io_configs_out !== model_flat()) begin n_errors++; $display("FAIL restart_configs: got %h expected %h", io_configs_out, model_flat()); end
   endtask

   task automatic test_reset_midload();
      io_mode = 1'b0; io_start = 1'b1;
      tick();
      io_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         io_in_valid = 1'b1; io_d_in = $urandom;
         tick();
      end
      io_in_valid = 1'b0; io_mode = 1'b1; io_rd_addr = 6'd3;
      reset = 1'b0;
      #2;
      model_clear();
      n_checks++;
      if (io_configs_out !== '0) begin n_errors++; $display("FAIL midreset_configs: got %h expected 0", io_configs_out); end
      n_checks++;
      if ({io_done, io_err, io_in_ready} !== 3'b000) begin n_errors++; $display("FAIL midreset_flags: got %b expected 000", {io_done, io_err, io_in_ready}); end
      n_checks++;
      if (io_rd_data !== '0) begin n_errors++; $display("FAIL midreset_rd_data: got %h expected 0", io_rd_data); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; io_mode = 1'b0;
      tick();
      for (int k = 0; k < NW; k++) words[k] = 32'h1000_0000 + WW'(k);
      run_load(0, "post_reset");
      n_checks++;
      if (io_configs_out[1119:1088] !== 32'h1000_0022) begin
         n_errors++; $display("FAIL post_reset_word34: got %h expected 10000022", io_configs_out[1119:1088]);
      end
   endtask

   initial begin
      test_reset();
      test_seq_load();
      test_readback();
      test_abort();
      test_backpressure();
      test_addressed();
      test_restart();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning width of one configuration word.
REQ-002 SHALL have parameter NUM_WORDS, default 35, meaning number of configuration words held (NUM_WORDS >= 2).
REQ-003 SHALL derive ADDR_W = clog2(NUM_WORDS) and CFG_W = WORD_W*NUM_WORDS; neither is overridable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 io_start  input  1  pulse: begin sequential load at word 0.
REQ-007 io_abort  input  1  pulse: cancel load in progress.
REQ-008 io_mode  input  1  0 = sequential auto-increment, 1 = addressed write.
REQ-009 io_addr  input  ADDR_W  target word for addressed writes.
REQ-010 io_in_valid  input  1  io_d_in carries a word.
REQ-011 io_in_ready  output  1  loader accepts a word this cycle.
REQ-012 io_d_in  input  WORD_W  configuration word.
REQ-013 io_commit  input  1  pulse: copy shadow bank to active bank (addressed mode).
REQ-014 io_rd_addr  input  ADDR_W  readback word select.
REQ-015 io_rd_data  output  WORD_W  registered readback of active word.
REQ-016 io_configs_out  output  CFG_W  active configuration; word k at bits [k*WORD_W +: WORD_W].
REQ-017 io_done  output  1  active bank holds a completed, committed load.
REQ-018 io_err  output  1  sticky error flag.

Function
REQ-019 SHALL hold two banks of NUM_WORDS words: shadow (written by loads) and active (drives io_configs_out); active changes only on commit.
REQ-020 SHALL implement states IDLE, LOAD, COMMIT, DONE.
REQ-021 IDLE: io_in_ready=1 only when io_mode=1; io_start -> LOAD with word counter cleared to 0.
REQ-022 LOAD (io_mode=0): io_in_ready=1; each cycle with io_in_valid&io_in_ready writes io_d_in to shadow[cnt] and increments cnt.
REQ-023 Accepting the word at cnt=NUM_WORDS-1 SHALL move to COMMIT next cycle; COMMIT is one cycle with io_in_ready=0, copying shadow to active at its end; then DONE.
REQ-024 DONE: io_done=1; io_start -> LOAD (io_done clears same edge); io_in_ready=0 unless io_mode=1.
REQ-025 io_abort in LOAD SHALL return to IDLE next cycle; shadow contents undefined, active and io_done unchanged; io_abort in other states ignored.
REQ-026 io_start in LOAD SHALL restart at cnt=0; word accepted in that same cycle is written at its old index; io_start and io_abort together: abort wins.
REQ-027 Addressed mode (io_mode=1, state IDLE or DONE): accepted word writes shadow[io_addr]; io_addr >= NUM_WORDS drops the word and sets io_err.
REQ-028 io_commit in IDLE or DONE SHALL copy shadow to active at end of that cycle and set io_done; io_commit in LOAD or COMMIT is ignored and sets io_err.
REQ-029 Write and commit in the same cycle: the written word SHALL be included in the commit.
REQ-030 io_rd_data SHALL equal active[io_rd_addr] one cycle after io_rd_addr is applied, reflecting an active update made in the same edge; out-of-range address returns 0.
REQ-031 io_err SHALL clear only on reset or on io_start.
REQ-032 io_configs_out SHALL be a direct register output, no combinational path from inputs.

Reset
REQ-033 On reset low: state IDLE, cnt 0, both banks 0, io_configs_out 0, io_rd_data 0, io_done 0, io_err 0, io_in_ready 0 regardless of io_mode.
REQ-034 Reset mid-LOAD or mid-COMMIT SHALL take effect immediately; no partial commit survives.

Structure
REQ-035 State enum and clog2 helper SHALL live in shared package config_pkg.
REQ-036 One sub-module config_bank (NUM_WORDS x WORD_W register array, one write port, parallel flat output) SHALL be instantiated twice.

Verification
REQ-037 Sequential load, defaults: start, 35 words 0x1000_0000+k back-to-back -> COMMIT after word 34, io_done=1, io_configs_out[31:0]=0x1000_0000, [1119:1088]=0x1000_0022.
REQ-038 Abort: after first load, start, 10 words 0xDEAD_BEEF, abort -> IDLE, io_configs_out unchanged, io_done stays 1.
REQ-039 Backpressure gaps: valid toggled every other cycle during load -> identical result to REQ-037 timing-independent; ready low in COMMIT.
REQ-040 Addressed mode: write 0xA5A5_A5A5 to addr 7 plus commit same cycle -> word 7 updated, other words unchanged; addr 40 -> io_err=1, no change.
REQ-041 Readback: rd_addr=34 after REQ-037 -> io_rd_data=0x1000_0022 next cycle; rd_addr=63 -> 0.
REQ-042 Reset asserted mid-load at word 20 -> all outputs 0 immediately; subsequent full load behaves as REQ-037.
